// File: rtl/core_decode.sv
// core_decode: RV32I decode stage with a single registered output bundle.
// Ports: clk/rst_n (async active-low reset), flush kills the held and incoming instruction;
// f_valid/f_ready/f_pc/f_ir form the fetch-side handshake; e_valid/e_ready carry the decoded
// bundle (e_pc, register indices, immediate, ALU op, operand selects and control flags) to execute.
module core_decode #(
  parameter bit NOP_ON_FENCE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_ir,
  output logic        f_ready,
  output logic        e_valid,
  input  logic        e_ready,
  output logic [31:0] e_pc,
  output logic [4:0]  e_rs1,
  output logic [4:0]  e_rs2,
  output logic [4:0]  e_rd,
  output logic        e_rd_we,
  output logic [31:0] e_imm,
  output logic [3:0]  e_alu_op,
  output logic        e_src_a_pc,
  output logic        e_src_b_imm,
  output logic [2:0]  e_funct3,
  output logic        e_branch,
  output logic        e_jump,
  output logic        e_jalr,
  output logic        e_mem_read,
  output logic        e_mem_write,
  output logic        e_illegal
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33, OP_MISC = 7'h0f;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        src_a_pc, src_b_imm;
    logic [2:0]  funct3;
    logic        branch, jump, jalr, mem_read, mem_write, illegal;
  } bundle_t;
  bundle_t d, q;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign op = f_ir[6:0];
  assign f3 = f_ir[14:12];
  assign f7 = f_ir[31:25];
  assign imm_i = {{20{f_ir[31]}}, f_ir[31:20]};
  assign imm_s = {{20{f_ir[31]}}, f_ir[31:25], f_ir[11:7]};
  assign imm_b = {{19{f_ir[31]}}, f_ir[31], f_ir[7], f_ir[30:25], f_ir[11:8], 1'b0};
  assign imm_u = {f_ir[31:12], 12'b0};
  assign imm_j = {{11{f_ir[31]}}, f_ir[31], f_ir[19:12], f_ir[20], f_ir[30:21], 1'b0};
  // funct3 -> ALU op; alt selects SUB/SRA where funct7 bit 5 applies
  function automatic logic [3:0] alu_sel(input logic [2:0] f, input logic alt);
    return f == 3'd0 ? {3'b0, alt} : f == 3'd5 ? (alt ? 4'd7 : 4'd6) :
           f < 3'd5 ? {1'b0, f} + 4'd1 : {1'b0, f} + 4'd2;
  endfunction
  always_comb begin
    d = '0;
    d.pc = f_pc;
    d.rs1 = f_ir[19:15];
    d.rs2 = f_ir[24:20];
    d.rd = f_ir[11:7];
    d.funct3 = f3;
    case (op)
      OP_LUI:   begin d.rd_we = 1'b1; d.imm = imm_u; d.alu_op = 4'd10; d.src_b_imm = 1'b1; end
      OP_AUIPC: begin d.rd_we = 1'b1; d.imm = imm_u; d.src_a_pc = 1'b1; d.src_b_imm = 1'b1; end
      OP_JAL:   begin d.rd_we = 1'b1; d.imm = imm_j; d.src_a_pc = 1'b1; d.src_b_imm = 1'b1; d.jump = 1'b1; end
      OP_JALR: begin
        d.illegal = f3 != 3'd0;
        d.rd_we = 1'b1; d.imm = imm_i; d.src_a_pc = 1'b1; d.src_b_imm = 1'b1; d.jump = 1'b1; d.jalr = 1'b1;
      end
      OP_BR: begin d.illegal = f3[2:1] == 2'b01; d.imm = imm_b; d.branch = 1'b1; end
      OP_LD: begin
        d.illegal = f3 == 3'd3 || f3[2:1] == 2'b11;
        d.rd_we = 1'b1; d.imm = imm_i; d.src_b_imm = 1'b1; d.mem_read = 1'b1;
      end
      OP_ST: begin d.illegal = f3 > 3'd2; d.imm = imm_s; d.src_b_imm = 1'b1; d.mem_write = 1'b1; end
      OP_IMM: begin
        // only the shift-immediates constrain funct7; SRAI is the sole 0x20 form
        d.illegal = f3[1:0] == 2'b01 && f7 != 7'h00 && !(f3 == 3'd5 && f7 == 7'h20);
        d.rd_we = 1'b1; d.imm = imm_i; d.src_b_imm = 1'b1; d.alu_op = alu_sel(f3, f3 == 3'd5 && f_ir[30]);
      end
      OP_REG: begin
        d.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        d.rd_we = 1'b1; d.alu_op = alu_sel(f3, f_ir[30]);
      end
      OP_MISC: d.illegal = !NOP_ON_FENCE || f3[2:1] != 2'b00;
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) {d.rd_we, d.branch, d.jump, d.jalr, d.mem_read, d.mem_write} = '0;
    if (d.rd == 5'd0) d.rd_we = 1'b0;
  end
  assign f_ready = !e_valid || e_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      e_valid <= 1'b0;
    end else if (flush) e_valid <= 1'b0;
    else if (f_valid && f_ready) begin
      q <= d;
      e_valid <= 1'b1;
    end else if (e_ready) e_valid <= 1'b0;
  assign {e_pc, e_rs1, e_rs2, e_rd, e_rd_we, e_imm, e_alu_op, e_src_a_pc, e_src_b_imm, e_funct3,
          e_branch, e_jump, e_jalr, e_mem_read, e_mem_write, e_illegal} = q;
endmodule

// File: tb/tb_core_decode.sv
// tb_core_decode: randomized and directed checks of core_decode against a mnemonic-level model.
module tb_core_decode;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, f_valid = 1'b0, e_ready = 1'b0;
  logic [31:0] f_pc = '0, f_ir = '0;
  logic        f_ready, e_valid, e_rd_we, e_src_a_pc, e_src_b_imm;
  logic        e_branch, e_jump, e_jalr, e_mem_read, e_mem_write, e_illegal;
  logic [31:0] e_pc, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [3:0]  e_alu_op;
  logic [2:0]  e_funct3;
  int n_vec = 0, n_err = 0;
  core_decode dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .f_valid(f_valid), .f_pc(f_pc), .f_ir(f_ir),
    .f_ready(f_ready), .e_valid(e_valid), .e_ready(e_ready), .e_pc(e_pc), .e_rs1(e_rs1),
    .e_rs2(e_rs2), .e_rd(e_rd), .e_rd_we(e_rd_we), .e_imm(e_imm), .e_alu_op(e_alu_op),
    .e_src_a_pc(e_src_a_pc), .e_src_b_imm(e_src_b_imm), .e_funct3(e_funct3),
    .e_branch(e_branch), .e_jump(e_jump), .e_jalr(e_jalr), .e_mem_read(e_mem_read),
    .e_mem_write(e_mem_write), .e_illegal(e_illegal)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        we, api, bi, br, jmp, jr, ld, st, ill, full;
  } exp_t;
  string alu_n[11] = '{"ADD", "SUB", "SLL", "SLT", "SLTU", "XOR", "SRL", "SRA", "OR", "AND", "PASSB"};
  string r_n[8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
  logic [6:0] opcs[11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
  bit   mv = 1'b0;
  exp_t mb = '0;
  function automatic exp_t ref_dec(input logic [31:0] pc, input logic [31:0] ir);
    exp_t e = '0;
    string m = "ADD";
    int f3 = int'(ir[14:12]);
    int f7 = int'(ir[31:25]);
    logic [31:0] ii, is, ib, iu, ij;
    ii = 32'($signed(ir) >>> 20);
    is = (ii & ~32'h1f) | {27'b0, ir[11:7]};
    ib = 32'((ir[31] ? -4096 : 0) + int'(ir[7]) * 2048 + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2);
    iu = ir & 32'hffff_f000;
    ij = 32'((ir[31] ? -(1 << 20) : 0) + int'(ir[19:12]) * 4096 + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2);
    e.pc = pc; e.rs1 = ir[19:15]; e.rs2 = ir[24:20]; e.rd = ir[11:7]; e.f3 = ir[14:12]; e.full = 1'b1;
    case (ir[6:0])
      7'h37: begin e.we = 1; e.imm = iu; m = "PASSB"; e.bi = 1; end
      7'h17: begin e.we = 1; e.imm = iu; e.api = 1; e.bi = 1; end
      7'h6f: begin e.we = 1; e.imm = ij; e.api = 1; e.bi = 1; e.jmp = 1; end
      7'h67: begin e.ill = f3 != 0; e.we = 1; e.imm = ii; e.api = 1; e.bi = 1; e.jmp = 1; e.jr = 1; end
      7'h63: begin e.ill = f3 == 2 || f3 == 3; e.imm = ib; e.br = 1; end
      7'h03: begin e.ill = !(f3 inside {0, 1, 2, 4, 5}); e.we = 1; e.imm = ii; e.bi = 1; e.ld = 1; end
      7'h23: begin e.ill = f3 > 2; e.imm = is; e.bi = 1; e.st = 1; end
      7'h13: begin
        m = r_n[f3];
        if (f3 == 1) e.ill = f7 != 0;
        if (f3 == 5) begin e.ill = !(f7 == 0 || f7 == 'h20); if (f7 == 'h20) m = "SRA"; end
        e.we = 1; e.imm = ii; e.bi = 1;
      end
      7'h33: begin
        m = r_n[f3];
        if (f7 == 'h20 && f3 == 0) m = "SUB";
        else if (f7 == 'h20 && f3 == 5) m = "SRA";
        else if (f7 != 0) e.ill = 1;
        e.we = 1;
      end
      7'h0f: begin e.ill = !(f3 inside {0, 1}); e.full = 0; end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.we = 0; e.br = 0; e.jmp = 0; e.jr = 0; e.ld = 0; e.st = 0; e.full = 0; end
    if (e.rd == 0) e.we = 0;
    for (int i = 0; i < 11; i++) if (alu_n[i] == m) e.alu = 4'(i);
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cmp();
    chk("e_valid", 32'(e_valid), 32'(mv));
    if (mv) begin
      chk("pc", e_pc, mb.pc); chk("rs1", 32'(e_rs1), 32'(mb.rs1)); chk("rs2", 32'(e_rs2), 32'(mb.rs2));
      chk("rd", 32'(e_rd), 32'(mb.rd)); chk("funct3", 32'(e_funct3), 32'(mb.f3));
      chk("illegal", 32'(e_illegal), 32'(mb.ill)); chk("rd_we", 32'(e_rd_we), 32'(mb.we));
      chk("branch", 32'(e_branch), 32'(mb.br)); chk("jump", 32'(e_jump), 32'(mb.jmp));
      chk("mem_read", 32'(e_mem_read), 32'(mb.ld)); chk("mem_write", 32'(e_mem_write), 32'(mb.st));
      if (mb.full) begin
        chk("imm", e_imm, mb.imm); chk("alu_op", 32'(e_alu_op), 32'(mb.alu));
        chk("src_a_pc", 32'(e_src_a_pc), 32'(mb.api)); chk("src_b_imm", 32'(e_src_b_imm), 32'(mb.bi));
        chk("jalr", 32'(e_jalr), 32'(mb.jr));
      end
    end
  endtask
  task automatic step(input bit fv, input logic [31:0] pc, input logic [31:0] ir, input bit er, input bit fl);
    f_valid = fv; f_pc = pc; f_ir = ir; e_ready = er; flush = fl;
    #1;
    chk("f_ready", 32'(f_ready), 32'(!mv || er));
    @(posedge clk);
    if (fl) mv = 1'b0;
    else if (fv && (!mv || er)) begin mv = 1'b1; mb = ref_dec(pc, ir); end
    else if (er) mv = 1'b0;
    @(negedge clk);
    cmp();
  endtask
  function automatic logic [31:0] rand_ir();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 12);
    if (k < 11) r[6:0] = opcs[k];
    if ((r[6:0] == 7'h13 || r[6:0] == 7'h33) && $urandom_range(0, 3) != 0)
      r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return r;
  endfunction
  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst e_valid", 32'(e_valid), 0); chk("rst f_ready", 32'(f_ready), 1);
    chk("rst e_pc", e_pc, 0); chk("rst e_imm", e_imm, 0); chk("rst e_rd_we", 32'(e_rd_we), 0);
    chk("rst e_illegal", 32'(e_illegal), 0); chk("rst e_alu_op", 32'(e_alu_op), 0);
    step(1, 32'h0, 32'h0050_0093, 1, 0);
    chk("addi rd", 32'(e_rd), 1); chk("addi imm", e_imm, 5); chk("addi alu", 32'(e_alu_op), 0);
    chk("addi src_b_imm", 32'(e_src_b_imm), 1); chk("addi rd_we", 32'(e_rd_we), 1);
    f_valid = 1'b1; f_ir = 32'h0010_0113;
    #2 rst_n = 1'b0;
    #1 chk("async rst e_valid", 32'(e_valid), 0);
    mv = 1'b0;
    f_valid = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), 32'h0010_0093 + 32'(i << 20), 1, 0);
    step(1, 32'h40, 32'h0020_8133, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h44, 32'h4020_8133, 0, 0);
      chk("bp f_ready", 32'(f_ready), 0);
    end
    step(1, 32'h44, 32'h4020_8133, 1, 0);
    chk("bp new alu", 32'(e_alu_op), 1);
    step(1, 32'h48, 32'h0030_0193, 1, 1);
    chk("flush e_valid", 32'(e_valid), 0);
    step(0, 32'h4c, 32'h0, 1, 0);
    step(1, 32'h50, 32'hfe00_0ee3, 1, 0);
    chk("beq imm", e_imm, 32'hffff_fffc); chk("beq branch", 32'(e_branch), 1); chk("beq rd_we", 32'(e_rd_we), 0);
    step(1, 32'h54, 32'h1234_52b7, 1, 0);
    chk("lui imm", e_imm, 32'h1234_5000); chk("lui alu", 32'(e_alu_op), 10);
    step(1, 32'h58, 32'hffdf_f06f, 1, 0);
    chk("jal rd_we", 32'(e_rd_we), 0); chk("jal jump", 32'(e_jump), 1); chk("jal imm", e_imm, 32'hffff_fffc);
    step(1, 32'h5c, 32'h0000_0000, 1, 0); chk("ill zero", 32'(e_illegal), 1);
    step(1, 32'h60, 32'hffff_ffff, 1, 0); chk("ill ones", 32'(e_illegal), 1);
    step(1, 32'h64, 32'h0000_0073, 1, 0); chk("ill ecall", 32'(e_illegal), 1);
    step(1, 32'h68, 32'h4020_e0b3, 1, 0); chk("ill or-sub", 32'(e_illegal), 1);
    chk("ill rd_we", 32'(e_rd_we), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom & ~32'h3, rand_ir(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
